// File: rtl/pipe_pkg.sv
// Shared types for elastic pipeline-stage registers: stage entry layout,
// the canonical NOP payload and the skid-buffer occupancy states.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned DEF_INSTR_W = 32;
  localparam int unsigned DEF_PC_W    = 32;
  localparam int unsigned DEF_EXC_W   = 3;
  localparam int unsigned DEF_IDX_W   = 4;

  // Default-width entry layout; stages built with other widths declare a
  // local struct with the same field names.
  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instruction;
    logic [DEF_PC_W-1:0]    PC;
    logic [DEF_EXC_W-1:0]   exception_vector;
    logic [DEF_IDX_W-1:0]   complete_idx;
    logic                   supervisor_mode;
  } stage_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  function automatic logic [1:0] occupancy_of(input state_t s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      EMPTY:   occ = 2'd0;
      ONE:     occ = 2'd1;
      TWO:     occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: valid/ready handshake with a 2-entry skid
// buffer, multi-source stall, flush, NOP bubble output and bubble counter.
module pipe_stage_skid #(
  parameter int unsigned         INSTR_W   = 32,
  parameter int unsigned         PC_W      = 32,
  parameter int unsigned         EXC_W     = 3,
  parameter int unsigned         IDX_W     = 4,
  parameter int unsigned         NUM_STALL = 2,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = INSTR_W'(pipe_pkg::NOP_INSTR),
  parameter int unsigned         CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   in_instruction,
  input  logic [PC_W-1:0]      in_PC,
  input  logic [EXC_W-1:0]     in_exception_vector,
  input  logic [IDX_W-1:0]     in_complete_idx,
  input  logic                 in_supervisor_mode,
  input  logic                 in_flush,
  input  logic [NUM_STALL-1:0] in_stall,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INSTR_W-1:0]   out_instruction,
  output logic [PC_W-1:0]      out_PC,
  output logic [EXC_W-1:0]     out_exception_vector,
  output logic [IDX_W-1:0]     out_complete_idx,
  output logic                 out_supervisor_mode,
  output logic                 out_bubble,
  output logic [1:0]           out_occupancy,
  output logic [CNT_W-1:0]     out_bubble_cycles
);

  import pipe_pkg::*;

  typedef struct packed {
    logic [INSTR_W-1:0] instruction;
    logic [PC_W-1:0]    PC;
    logic [EXC_W-1:0]   exception_vector;
    logic [IDX_W-1:0]   complete_idx;
    logic               supervisor_mode;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, skid_q, in_entry;
  logic   sup_q;

  logic stall_any, main_valid, in_fire, out_fire, bubble_inc;
  logic load_main_in, load_main_skid, load_skid_in;

  assign in_entry = '{
    instruction:      in_instruction,
    PC:               in_PC,
    exception_vector: in_exception_vector,
    complete_idx:     in_complete_idx,
    supervisor_mode:  in_supervisor_mode
  };

  assign stall_any  = |in_stall;
  assign main_valid = (state_q != EMPTY);
  assign in_ready   = (state_q != TWO) && !stall_any && !in_flush;
  assign out_valid  = main_valid && !stall_any;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;

  // Stall needs no explicit branch: it forces both in_fire and out_fire low.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (in_flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            state_d      = TWO;
            load_skid_in = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload registers carry no reset; validity is tracked by state_q alone.
  always_ff @(posedge clk) begin
    if (load_main_in) begin
      main_q <= in_entry;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end
    if (load_skid_in) begin
      skid_q <= in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sup_q <= 1'b0;
    end else if (load_main_in) begin
      sup_q <= in_supervisor_mode;
    end else if (load_main_skid) begin
      sup_q <= skid_q.supervisor_mode;
    end
  end

  assign out_instruction      = out_valid ? main_q.instruction      : NOP_INSTR;
  assign out_PC               = out_valid ? main_q.PC               : '0;
  assign out_exception_vector = out_valid ? main_q.exception_vector : '0;
  assign out_complete_idx     = out_valid ? main_q.complete_idx     : '0;
  assign out_supervisor_mode  = sup_q;
  assign out_bubble           = !out_valid;
  assign out_occupancy        = occupancy_of(state_q);

  assign bubble_inc = out_ready && !main_valid && !stall_any && !in_flush;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (bubble_inc),
    .count (out_bubble_cycles)
  );

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised elastic pipeline-stage register, successor to the fixed IF/ID latch, usable at any stage boundary (IF/ID, ID/EX, ...). Replaces write-disable stalling with a valid/ready handshake backed by a 2-entry skid buffer, so backpressure never drops or duplicates an instruction. Supports multiple stall sources, flush, NOP bubble injection and a saturating bubble-cycle performance counter.

Parameters:
INSTR_W, 32, instruction payload width
PC_W, 32, PC width
EXC_W, 3, exception vector width
IDX_W, 4, ROB complete-index width
NUM_STALL, 2, number of independent stall sources (e.g. i-cache, d-cache)
NOP_INSTR, 32'h00000013, payload driven when output is a bubble (addi x0,x0,0)
CNT_W, 32, bubble counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept this cycle
in_instruction  in  INSTR_W  instruction
in_PC  in  PC_W  PC
in_exception_vector  in  EXC_W  exception bits
in_complete_idx  in  IDX_W  ROB index
in_supervisor_mode  in  1  privilege of the entry
in_flush  in  1  discard all held entries
in_stall  in  NUM_STALL  any bit set freezes stage
out_valid  out  1  out_* payload valid
out_ready  in  1  downstream accepts
out_instruction  out  INSTR_W  held instruction, NOP_INSTR when !out_valid
out_PC  out  PC_W  held PC, 0 when !out_valid
out_exception_vector  out  EXC_W  0 when !out_valid
out_complete_idx  out  IDX_W  0 when !out_valid
out_supervisor_mode  out  1  privilege of last entry loaded into main; held across bubbles
out_bubble  out  1  = !out_valid
out_occupancy  out  2  entries held (0..2)
out_bubble_cycles  out  CNT_W  saturating count of starved cycles

Behaviour:
- Storage: main entry (drives outputs) + skid entry. States EMPTY (0), ONE (main), TWO (main+skid).
- stall_any = |in_stall. in_ready = !skid_valid && !stall_any && !in_flush. out_valid = main_valid && !stall_any.
- in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- EMPTY: in_fire -> ONE, main <= in.
- ONE: in_fire && out_fire -> ONE, main <= in; in_fire && !out_fire -> TWO, skid <= in; !in_fire && out_fire -> EMPTY; else hold.
- TWO: no in_fire possible; out_fire -> ONE, main <= skid; else hold.
- Stall: state and entries frozen; out_valid = 0; counter not incremented.
- Flush (priority over stall and handshakes): next state EMPTY, both entries invalidated, in-cycle transfers ignored; out_supervisor_mode held.
- Reset: as flush plus out_supervisor_mode = 0, out_bubble_cycles = 0. All outputs after reset: out_valid 0, out_instruction NOP_INSTR, PC/exc/idx 0, out_bubble 1, out_occupancy 0, in_ready 1 (no stall).
- Payload outputs are muxed from main: NOP/zero when !out_valid (including while stalled).
- Order preserved: main always older than skid. Latency 1 cycle when empty and unstalled.
- out_bubble_cycles increments when out_ready && !main_valid && !stall_any && !in_flush; saturates at all-ones; cleared only by reset.

Decomposition:
- Shared package pipe_pkg: stage_entry_t struct {instruction, PC, exception_vector, complete_idx, supervisor_mode}, NOP_INSTR constant, state enum {EMPTY, ONE, TWO}.
- Sub-module sat_counter (CNT_W, inc, clear) for the perf counter; handshake/storage stays in top.

Test Plan:
- Reset then in_valid=1, PC=0x100, out_ready=1 -> next cycle out_valid=1, out_PC=0x100, occupancy 1; next idle cycle out_instruction=0x00000013, out_bubble=1.
- Stream PC 0x0,0x4,0x8 with out_ready=0 from cycle 1 -> occupancy 2, in_ready=0, 0x8 held upstream; release out_ready -> outputs 0x0,0x4,0x8 in order, none lost or duplicated.
- Occupancy 2, in_stall=2'b01 for 3 cycles with out_ready=1 -> out_valid=0, occupancy stays 2; clear stall -> 0x0 emitted first.
- Occupancy 2 plus in_flush=1 with in_valid=1 and in_stall=2'b10 -> next cycle occupancy 0, out_valid=0, incoming entry dropped, supervisor bit unchanged.
- CNT_W=3, empty, out_ready=1 for 10 cycles -> out_bubble_cycles saturates at 7; flush leaves it 7; reset clears to 0.
- Load supervisor=1 entry, drain, then bubble -> out_supervisor_mode stays 1 until next load or reset.
